board_generator: RTL and testbench

- Upstream stage of the memory matrix game; produces the solution board that the game controller and datapath consume.
- On a start request it draws a random tile pattern with exactly the requested number of lit tiles.
- Draws come from a free-running LFSR, so human button timing adds entropy.
- Presents the board with a valid flag and holds it until the next request.

---
 rtl/board_generator.sv | 187 ++++++++++++++++++
 tb/tb_board_generator.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/board_generator.sv
// -----------------------------------------------------------------------------
// board_generator
//   Upstream stage of the memory matrix game. On a start request it draws a
//   random tile pattern containing exactly the requested number of lit tiles
//   and presents it with a valid flag until the next request. Draw indices
//   come from a free-running Galois LFSR, so the timing of the player's button
//   press adds entropy. If random draws keep landing on already-lit tiles, a
//   deterministic fill (lowest clear tile first) completes the board.
//
// Optional feature (compile-time macro BOARD_GEN_NO_REPEAT_EN):
//   When defined, a board identical to the previously issued one is rejected
//   and regenerated (up to 4 retries), unless the board is completely lit.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   start        in   generation request, level-sampled in IDLE/DONE
//   num_tiles    in   requested lit-tile count (clamped to 1..BOARD_W)
//   board        out  solution board; zero unless board_valid
//   board_valid  out  board is complete and stable
//   busy         out  generation in progress
// -----------------------------------------------------------------------------
module board_generator #(
   parameter int                BOARD_W   = 8,
   parameter int                LFSR_W    = 16,
   parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
   parameter int                MAX_DRAWS = 64
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [$clog2(BOARD_W):0]  num_tiles,
   output logic [BOARD_W-1:0]        board,
   output logic                      board_valid,
   output logic                      busy
);

   localparam int IDX_W = $clog2(BOARD_W);
   localparam int CNT_W = IDX_W + 1;
   localparam int DRW_W = $clog2(MAX_DRAWS + 1);

   localparam logic [LFSR_W-1:0] TAPS      = LFSR_W'(16'hB400);
   // An all-zero seed would lock the LFSR, so substitute 1.
   localparam logic [LFSR_W-1:0] SEED_INIT = (SEED == '0) ? LFSR_W'(1) : SEED;
   localparam logic [CNT_W-1:0]  BW        = CNT_W'(BOARD_W);
   localparam logic [DRW_W-1:0]  MAXD      = DRW_W'(MAX_DRAWS);

   typedef enum logic [1:0] {S_IDLE, S_GEN, S_FILL, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
   logic [BOARD_W-1:0]  work_q, work_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0]    tgt_q, tgt_d;
   logic [DRW_W-1:0]    drw_q, drw_d;
   logic [BOARD_W-1:0]  board_q;
   logic                valid_q;
   logic                busy_q;
   logic [IDX_W-1:0]    idx;
   logic                done_req;

`ifdef BOARD_GEN_NO_REPEAT_EN
   logic [BOARD_W-1:0]  last_q, last_d;
   logic [2:0]          retry_q, retry_d;
`endif

   // Clamp the requested count into 1..BOARD_W.
   function automatic logic [CNT_W-1:0] clamp_target(input logic [CNT_W-1:0] n);
      if (n == '0)
         return CNT_W'(1);
      else if (n > BW)
         return BW;
      else
         return n;
   endfunction

   // One-hot mask of the lowest clear bit: adding 1 ripples into exactly that bit.
   function automatic logic [BOARD_W-1:0] lowest_zero(input logic [BOARD_W-1:0] w);
      return ~w & (w + BOARD_W'(1));
   endfunction

   assign board       = board_q;
   assign board_valid = valid_q;
   assign busy        = busy_q;

   always_comb begin
      state_d  = state_q;
      work_d   = work_q;
      cnt_d    = cnt_q;
      tgt_d    = tgt_q;
      drw_d    = drw_q;
      done_req = 1'b0;
      idx      = lfsr_q[IDX_W-1:0];
      lfsr_d   = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
`ifdef BOARD_GEN_NO_REPEAT_EN
      last_d   = last_q;
      retry_d  = retry_q;
`endif

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_GEN;
               work_d  = '0;
               cnt_d   = '0;
               drw_d   = '0;
               tgt_d   = clamp_target(num_tiles);
`ifdef BOARD_GEN_NO_REPEAT_EN
               retry_d = '0;
`endif
            end
         end
         S_GEN: begin
            if (!work_q[idx]) begin
               work_d[idx] = 1'b1;
               cnt_d       = cnt_q + CNT_W'(1);
            end
            drw_d = drw_q + DRW_W'(1);
            // A hit on the final draw still completes the board.
            if (cnt_d == tgt_q)
               done_req = 1'b1;
            else if (drw_d == MAXD)
               state_d = S_FILL;
         end
         S_FILL: begin
            work_d = work_q | lowest_zero(work_q);
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_d == tgt_q)
               done_req = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      if (done_req) begin
`ifdef BOARD_GEN_NO_REPEAT_EN
         // A fully lit board has only one pattern, so it is never retried.
         if ((work_d == last_q) && (tgt_q < BW) && (retry_q < 3'd4)) begin
            state_d = S_GEN;
            work_d  = '0;
            cnt_d   = '0;
            drw_d   = '0;
            retry_d = retry_q + 3'd1;
         end else begin
            state_d = S_DONE;
            last_d  = work_d;
            retry_d = '0;
         end
`else
         state_d = S_DONE;
`endif
      end
   end

   // Outputs are registered from the next state so they align with it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         lfsr_q  <= SEED_INIT;
         work_q  <= '0;
         cnt_q   <= '0;
         tgt_q   <= '0;
         drw_q   <= '0;
         board_q <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
`ifdef BOARD_GEN_NO_REPEAT_EN
         last_q  <= '0;
         retry_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         tgt_q   <= tgt_d;
         drw_q   <= drw_d;
         board_q <= (state_d == S_DONE) ? work_d : '0;
         valid_q <= (state_d == S_DONE);
         busy_q  <= (state_d == S_GEN) || (state_d == S_FILL);
`ifdef BOARD_GEN_NO_REPEAT_EN
         last_q  <= last_d;
         retry_q <= retry_d;
`endif
      end
   end

endmodule

// File: tb/tb_board_generator.sv
module tb_board_generator;

   logic       clk = 1'b0;
   logic       reset;
   logic       start, start1;
   logic [3:0] num_tiles, num1;
   logic [7:0] board, board1;
   logic       bv, bv1, busy, busy1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   board_generator #(.BOARD_W(8)) dut (
      .clk(clk), .reset(reset), .start(start), .num_tiles(num_tiles),
      .board(board), .board_valid(bv), .busy(busy));

   board_generator #(.BOARD_W(8), .MAX_DRAWS(1)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .num_tiles(num1),
      .board(board1), .board_valid(bv1), .busy(busy1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse(input bit sel);
      @(negedge clk);
      if (sel) start1 = 1'b1; else start = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      start1 = 1'b0;
   endtask

   // Called one cycle after the start edge; waits for board_valid while
   // checking that the board stays hidden and busy stays high meanwhile.
   task automatic wait_valid(input bit sel, input string tag, output int lat);
      logic v, bz;
      logic [7:0] b;
      lat = 0;
      v  = sel ? bv1 : bv;
      bz = sel ? busy1 : busy;
      b  = sel ? board1 : board;
      chk({tag, "_busy_rise"}, 32'(bz), 32'd1);
      chk({tag, "_valid_low"}, 32'(v), 32'd0);
      chk({tag, "_board_zero"}, 32'(b), 32'd0);
      while (!v && lat < 200) begin
         @(negedge clk);
         lat++;
         v  = sel ? bv1 : bv;
         bz = sel ? busy1 : busy;
         b  = sel ? board1 : board;
         if (!v) begin
            chk({tag, "_hidden"}, 32'(b), 32'd0);
            chk({tag, "_busy"}, 32'(bz), 32'd1);
         end
      end
      if (!v) chk({tag, "_timeout"}, 32'd0, 32'd1);
      else    chk({tag, "_busy_fall"}, 32'(bz), 32'd0);
   endtask

   initial begin
      int lat;
      logic [7:0] prev;

      reset = 1'b1; start = 1'b0; start1 = 1'b0;
      num_tiles = 4'd0; num1 = 4'd0;
      repeat (3) @(negedge clk);
      chk("rst_board", 32'(board), 32'd0);
      chk("rst_valid", 32'(bv), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_board1", 32'(board1), 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);

      // Three tiles: latency window, popcount, stability.
      num_tiles = 4'd3;
      pulse(0);
      wait_valid(0, "t3", lat);
      chk("t3_pop", 32'($countones(board)), 32'd3);
      chk("t3_lat", 32'((lat >= 3) && (lat <= 72)), 32'd1);
      prev = board;
      repeat (100) begin
         @(negedge clk);
         chk("t3_hold", 32'({bv, busy, board}), 32'({1'b1, 1'b0, prev}));
      end

      // Zero clamps up to one tile.
      num_tiles = 4'd0;
      pulse(0);
      wait_valid(0, "t0", lat);
      chk("t0_pop", 32'($countones(board)), 32'd1);

      // Above BOARD_W clamps to a fully lit board.
      num_tiles = 4'd9;
      pulse(0);
      wait_valid(0, "t9", lat);
      chk("t9_board", 32'(board), 32'hFF);

      // One random draw, then deterministic fill of the lowest clear tiles.
      num1 = 4'd5;
      pulse(1);
      wait_valid(1, "fill", lat);
      chk("fill_lat", 32'(lat), 32'd5);
      chk("fill_pop", 32'($countones(board1)), 32'd5);
      chk("fill_low", 32'(board1 & 8'h0F), 32'h0F);

      // start during GEN is ignored; the original target is kept.
      num_tiles = 4'd6;
      pulse(0);
      num_tiles = 4'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_valid(0, "regen", lat);
      chk("regen_pop", 32'($countones(board)), 32'd6);

      // Asynchronous reset in the middle of GEN.
      num_tiles = 4'd8;
      pulse(0);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("arst_board", 32'(board), 32'd0);
      chk("arst_valid", 32'(bv), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      num_tiles = 4'd4;
      pulse(0);
      wait_valid(0, "post_rst", lat);
      chk("post_rst_pop", 32'($countones(board)), 32'd4);

      // Back-to-back requests for two tiles.
      num_tiles = 4'd2;
      prev = 8'h00;
      for (int i = 0; i < 20; i++) begin
         pulse(0);
         wait_valid(0, "b2b", lat);
         chk("b2b_pop", 32'($countones(board)), 32'd2);
`ifdef BOARD_GEN_NO_REPEAT_EN
         chk("b2b_norepeat", 32'(board != prev), 32'd1);
`endif
         prev = board;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
